// File: rtl/message_printer_ctrl_pkg.sv
// Shared constants, state encodings and request payload for the message printer.
package message_printer_ctrl_pkg;

   localparam int unsigned MSG_LEN  = 4;   // bytes per message
   localparam int unsigned NUM_MSGS = 3;   // valid message indices 0..NUM_MSGS-1
   localparam int unsigned ADDR_W   = 5;   // message ROM address width
   localparam int unsigned SEL_W    = 2;   // message index width
   localparam int unsigned DATA_W   = 8;   // byte width
   localparam int unsigned IDX_W    = 2;   // byte-within-message counter width
   localparam int unsigned STATE_W  = 3;

   // Sequencer state encodings
   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_FETCH = 3'd1;
   localparam logic [STATE_W-1:0] ST_LOAD  = 3'd2;
   localparam logic [STATE_W-1:0] ST_SEND  = 3'd3;
   localparam logic [STATE_W-1:0] ST_GAP   = 3'd4;

   // Message indices: " 0\n\r", " 1\n\r", " X\n\r"
   localparam logic [SEL_W-1:0] MSG_ZERO = 2'd0;
   localparam logic [SEL_W-1:0] MSG_ONE  = 2'd1;
   localparam logic [SEL_W-1:0] MSG_X    = 2'd2;

   typedef struct packed {
      logic [SEL_W-1:0] sel;
   } msg_req_t;

   // ROM base address of a message; max base+idx is 11, fits ADDR_W without wrap
   function automatic logic [ADDR_W-1:0] msg_base(input logic [SEL_W-1:0] sel);
      return ADDR_W'(sel) * ADDR_W'(MSG_LEN);
   endfunction

endpackage

// File: rtl/message_printer_ctrl_msg_req_slot.sv
// msg_req_slot: one-entry request register with valid/ready handshake.
// Out-of-range indices are accepted but not stored, and flagged with a 1-cycle drop pulse.
// Ports: clk, rst (async active-high), valid_i/sel_i (request), ready_o (slot free),
//        pop_i (consumer takes entry), full_o/req_o (stored entry), drop_o (bad index).
module msg_req_slot
   import message_printer_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   input  logic [SEL_W-1:0] sel_i,
   output logic             ready_o,
   input  logic             pop_i,
   output logic             full_o,
   output msg_req_t         req_o,
   output logic             drop_o
);

   logic     full_q, full_d;
   logic     ready_q, ready_d;
   logic     drop_q, drop_d;
   msg_req_t req_q, req_d;
   logic     accept_c;

   // Handshake only while empty, so a pop and a load never target the same entry
   always_comb begin
      full_d   = full_q;
      req_d    = req_q;
      drop_d   = 1'b0;
      accept_c = valid_i && ready_q;
      if (pop_i) begin
         full_d = 1'b0;
      end
      if (accept_c) begin
         if (sel_i < SEL_W'(NUM_MSGS)) begin
            full_d    = 1'b1;
            req_d.sel = sel_i;
         end else begin
            drop_d = 1'b1;
         end
      end
      ready_d = !full_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q  <= 1'b0;
         ready_q <= 1'b1;
         drop_q  <= 1'b0;
         req_q   <= '0;
      end else begin
         full_q  <= full_d;
         ready_q <= ready_d;
         drop_q  <= drop_d;
         req_q   <= req_d;
      end
   end

   assign ready_o = ready_q;
   assign full_o  = full_q;
   assign req_o   = req_q;
   assign drop_o  = drop_q;

endmodule

// File: rtl/message_printer_ctrl.sv
// message_printer_ctrl: walks a 4-byte message in the message ROM and hands each
// byte to the UART tx interface under the tx_busy handshake; one further request
// can be queued while a message prints.
// Ports: clk, rst (async active-high); msg_valid/msg_sel/msg_ready request handshake;
//        rom_addr/rom_data message ROM (1-clk latency); tx_data/new_tx_data/tx_busy
//        UART tx; busy (message in progress); drop (out-of-range request pulse).
module message_printer_ctrl
   import message_printer_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              msg_valid,
   input  logic [SEL_W-1:0]  msg_sel,
   output logic              msg_ready,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] tx_data,
   output logic              new_tx_data,
   input  logic              tx_busy,
   output logic              busy,
   output logic              drop
);

   logic [STATE_W-1:0] state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [ADDR_W-1:0]  base_q, base_d;
   logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
   logic [DATA_W-1:0]  tx_data_q, tx_data_d;
   logic               new_tx_q, new_tx_d;
   logic               busy_q, busy_d;
   logic               pop_c;
   logic               slot_full;
   msg_req_t           slot_req;

   msg_req_slot u_slot (
      .clk     (clk),
      .rst     (rst),
      .valid_i (msg_valid),
      .sel_i   (msg_sel),
      .ready_o (msg_ready),
      .pop_i   (pop_c),
      .full_o  (slot_full),
      .req_o   (slot_req),
      .drop_o  (drop)
   );

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      base_d     = base_q;
      rom_addr_d = rom_addr_q;
      tx_data_d  = tx_data_q;
      new_tx_d   = 1'b0;
      pop_c      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (slot_full) begin
               base_d  = msg_base(slot_req.sel);
               idx_d   = '0;
               pop_c   = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            rom_addr_d = base_q + ADDR_W'(idx_q);
            state_d    = ST_LOAD;
         end
         // ROM data appears one clock after the address register changes
         ST_LOAD: state_d = ST_SEND;
         ST_SEND: begin
            if (!tx_busy) begin
               tx_data_d = rom_data;
               new_tx_d  = 1'b1;
               state_d   = ST_GAP;
            end
         end
         // Guard cycle: the UART raises tx_busy one clock after the strobe
         ST_GAP: begin
            if (idx_q == IDX_W'(MSG_LEN - 1)) begin
               state_d = ST_IDLE;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         base_q     <= '0;
         rom_addr_q <= '0;
         tx_data_q  <= '0;
         new_tx_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         base_q     <= base_d;
         rom_addr_q <= rom_addr_d;
         tx_data_q  <= tx_data_d;
         new_tx_q   <= new_tx_d;
         busy_q     <= busy_d;
      end
   end

   assign rom_addr    = rom_addr_q;
   assign tx_data     = tx_data_q;
   assign new_tx_data = new_tx_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_message_printer_ctrl.sv
// Self-checking bench for message_printer_ctrl: table-driven single requests,
// directed multi-cycle sequences, and a randomized run against a byte-stream model.
module tb_message_printer_ctrl;
   import message_printer_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       msg_valid;
   logic [1:0] msg_sel;
   logic       msg_ready;
   logic [4:0] rom_addr;
   logic [7:0] rom_data;
   logic [7:0] tx_data;
   logic       new_tx_data;
   logic       tx_busy;
   logic       busy;
   logic       drop;

   logic [7:0] rom [0:31];
   int         n_checks = 0;
   int         n_pass   = 0;
   int         cyc      = 0;
   logic [7:0] mon_b [$];
   int         mon_c [$];

   typedef struct {
      logic [1:0]  sel;
      logic        exp_drop;
      int          exp_n;
      logic [31:0] exp_msg;
   } vec_t;
   vec_t vecs [5];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rom_data <= rom[rom_addr];
   always @(negedge clk) begin
      if (new_tx_data) begin
         mon_b.push_back(tx_data);
         mon_c.push_back(cyc);
      end
   end

   message_printer_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .msg_valid   (msg_valid),
      .msg_sel     (msg_sel),
      .msg_ready   (msg_ready),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .tx_data     (tx_data),
      .new_tx_data (new_tx_data),
      .tx_busy     (tx_busy),
      .busy        (busy),
      .drop        (drop)
   );

   function automatic logic [7:0] exp_byte(input int sel, input int i);
      case (i)
         0: return 8'h20;
         1: return (sel == 0) ? 8'h30 : (sel == 1) ? 8'h31 : 8'h58;
         2: return 8'h0A;
         default: return 8'h0D;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Hold a request until the handshake completes; acc is the accepting edge's cycle
   task automatic send_req(input logic [1:0] sel, output int acc, output bit ok);
      msg_valid = 1'b1;
      msg_sel   = sel;
      ok        = 1'b0;
      for (int t = 0; t < 60 && !ok; t++) begin
         ok = msg_ready;
         tick();
      end
      acc       = cyc;
      msg_valid = 1'b0;
      if (!ok) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_strobes(input int n, input int budget);
      int b;
      b = budget;
      while (mon_b.size() < n && b > 0) begin
         tick();
         b--;
      end
      if (mon_b.size() < n) check("strobe_timeout", mon_b.size(), n);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      msg_valid = 1'b0;
      msg_sel   = 2'd0;
      tx_busy   = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  acc, acc2, fall;
      bit  ok, flag;
      logic [7:0]  td;
      logic [63:0] exp8;
      logic [7:0]  exp_q [$];
      bit          hs_prev;
      logic [1:0]  sel_prev;
      int          busy_cnt;
      logic        exp_d;

      for (int i = 0; i < 32; i++) rom[i] = 8'hEE;
      rom[0] = 8'h20; rom[1] = 8'h30; rom[2]  = 8'h0A; rom[3]  = 8'h0D;
      rom[4] = 8'h20; rom[5] = 8'h31; rom[6]  = 8'h0A; rom[7]  = 8'h0D;
      rom[8] = 8'h20; rom[9] = 8'h58; rom[10] = 8'h0A; rom[11] = 8'h0D;

      vecs[0] = '{sel: MSG_ONE,  exp_drop: 1'b0, exp_n: 4, exp_msg: 32'h20310A0D};
      vecs[1] = '{sel: MSG_ZERO, exp_drop: 1'b0, exp_n: 4, exp_msg: 32'h20300A0D};
      vecs[2] = '{sel: 2'd3,     exp_drop: 1'b1, exp_n: 0, exp_msg: 32'h0};
      vecs[3] = '{sel: MSG_X,    exp_drop: 1'b0, exp_n: 4, exp_msg: 32'h20580A0D};
      vecs[4] = '{sel: MSG_ONE,  exp_drop: 1'b0, exp_n: 4, exp_msg: 32'h20310A0D};

      // Reset values while reset is held
      rst = 1'b1; msg_valid = 1'b0; msg_sel = 2'd0; tx_busy = 1'b0;
      tick();
      tick();
      check("rst_ready", msg_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_strobe", new_tx_data, 0);
      check("rst_drop", drop, 0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_tx_data", tx_data, 0);
      rst = 1'b0;
      tick();

      // Table: single requests from idle, latency, spacing, busy and drop
      foreach (vecs[v]) begin
         mon_b.delete(); mon_c.delete();
         check("idle_ready", msg_ready, 1);
         send_req(vecs[v].sel, acc, ok);
         check("drop_flag", drop, vecs[v].exp_drop);
         if (vecs[v].exp_n == 0) begin
            tick();
            check("drop_one_cycle", drop, 0);
            flag = 1'b0;
            repeat (10) begin
               if (busy) flag = 1'b1;
               tick();
            end
            check("drop_no_busy", flag, 0);
            check("drop_no_strobe", mon_b.size(), 0);
         end else begin
            wait_strobes(vecs[v].exp_n, 60);
            check("busy_in_last_gap", busy, 1);
            tick();
            check("busy_fall", busy, 0);
            check("strobe_count", mon_b.size(), vecs[v].exp_n);
            for (int i = 0; i < mon_b.size() && i < vecs[v].exp_n; i++) begin
               check("byte", mon_b[i], vecs[v].exp_msg[31-8*i -: 8]);
               check("strobe_time", mon_c[i], acc + 4 + 4 * i);
            end
         end
         tick();
      end

      // Back-to-back sel=0 then sel=2
      mon_b.delete(); mon_c.delete();
      send_req(MSG_ZERO, acc, ok);
      send_req(MSG_X, acc2, ok);
      check("queued_ready_low", msg_ready, 0);
      wait_strobes(8, 100);
      check("b2b_count", mon_b.size(), 8);
      exp8 = 64'h20300A0D_20580A0D;
      for (int i = 0; i < mon_b.size() && i < 8; i++)
         check("b2b_byte", mon_b[i], exp8[63-8*i -: 8]);
      if (mon_c.size() >= 5) check("b2b_one_idle", mon_c[4] - mon_c[3], 5);
      tick(); tick();
      check("b2b_idle", busy, 0);

      // tx_busy held for 10 clocks ahead of byte 2
      mon_b.delete(); mon_c.delete();
      send_req(MSG_X, acc, ok);
      wait_strobes(2, 40);
      tx_busy = 1'b1;
      td      = tx_data;
      flag    = 1'b1;
      repeat (10) begin
         tick();
         if (tx_data !== td || new_tx_data !== 1'b0) flag = 1'b0;
      end
      tx_busy = 1'b0;
      fall    = cyc;
      check("hold_stable", flag, 1);
      check("hold_no_strobe", mon_b.size(), 2);
      wait_strobes(3, 10);
      if (mon_b.size() >= 3) begin
         check("hold_byte", mon_b[2], 8'h0A);
         check("hold_release_time", mon_c[2], fall + 1);
      end
      wait_strobes(4, 20);
      if (mon_b.size() >= 4) check("hold_last", mon_b[3], 8'h0D);
      tick(); tick();

      // Async reset after 2nd byte with the slot full
      mon_b.delete(); mon_c.delete();
      send_req(MSG_ONE, acc, ok);
      send_req(MSG_ZERO, acc2, ok);
      wait_strobes(2, 40);
      check("pre_rst_full", msg_ready, 0);
      #2 rst = 1'b1;
      #1;
      check("arst_ready", msg_ready, 1);
      check("arst_busy", busy, 0);
      check("arst_strobe", new_tx_data, 0);
      check("arst_rom_addr", rom_addr, 0);
      check("arst_tx_data", tx_data, 0);
      check("arst_drop", drop, 0);
      tick(); tick();
      rst = 1'b0;
      repeat (30) tick();
      check("arst_no_more", mon_b.size(), 2);
      check("arst_idle", busy, 0);

      // Third request while the slot is full is refused
      mon_b.delete(); mon_c.delete();
      send_req(MSG_ONE, acc, ok);
      send_req(MSG_X, acc2, ok);
      msg_valid = 1'b1;
      msg_sel   = MSG_ZERO;
      flag      = 1'b0;
      repeat (6) begin
         if (msg_ready) flag = 1'b1;
         tick();
      end
      msg_valid = 1'b0;
      check("third_refused", flag, 0);
      wait_strobes(8, 100);
      repeat (12) tick();
      check("third_count", mon_b.size(), 8);
      exp8 = 64'h20310A0D_20580A0D;
      for (int i = 0; i < mon_b.size() && i < 8; i++)
         check("third_byte", mon_b[i], exp8[63-8*i -: 8]);

      // Randomized requests and UART back-pressure against a byte-stream model
      do_reset();
      hs_prev  = 1'b0;
      sel_prev = 2'd0;
      busy_cnt = 0;
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         exp_d = 1'b0;
         if (hs_prev) begin
            if (sel_prev < 2'd3) begin
               for (int k = 0; k < 4; k++) exp_q.push_back(exp_byte(int'(sel_prev), k));
            end else begin
               exp_d = 1'b1;
            end
         end
         check("rnd_drop", drop, exp_d);
         if (new_tx_data) begin
            check("rnd_busy_respected", tx_busy, 0);
            if (exp_q.size() == 0) check("rnd_unexpected_strobe", tx_data, 32'h100);
            else check("rnd_byte", tx_data, exp_q.pop_front());
            busy_cnt = $urandom_range(1, 6);
         end
         if ((exp_q.size() + 3) / 4 >= 2) check("rnd_ready_low", msg_ready, 0);
         if (busy_cnt > 0) begin
            tx_busy = 1'b1;
            busy_cnt--;
         end else begin
            tx_busy = ($urandom_range(0, 7) == 0);
         end
         msg_valid = (i < 550) && ($urandom_range(0, 3) == 0);
         msg_sel   = 2'($urandom_range(0, 3));
         hs_prev   = msg_valid && msg_ready;
         sel_prev  = msg_sel;
      end
      tx_busy = 1'b0;
      tick(); tick();
      check("rnd_drained", exp_q.size(), 0);
      check("rnd_idle", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
